// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures InstIn into the IF/ID register,
// and handles stall, redirect with flush, and halt. Optional FETCH_ALIGN_CHECK_EN
// rejects misaligned redirects and raises a sticky MisalignErr.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPc,
  input  logic        Halt,
  input  logic [31:0] InstIn,
  output logic [31:0] Pc,
  output logic [31:0] IfId_Inst,
  output logic [31:0] IfId_PcPlus4,
  output logic        IfId_Valid,
  output logic        Halted,
  output logic [31:0] FetchCount,
  output logic        MisalignErr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FLUSH  = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_plus;
  logic [31:0] redirect_target;
  logic        redirect_ok;

  assign pc_plus         = Pc + PC_STEP;
  assign redirect_target = RedirectPc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_ok = (RedirectPc[1:0] == 2'b00);
`else
  assign redirect_ok = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_FLUSH;
    else     state <= state_nxt;
  end

  // A rejected (misaligned) redirect leaves the state where it was.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FLUSH:  state_nxt = Halt ? S_HALTED : S_RUN;
      S_RUN: begin
        if (Redirect)  state_nxt = S_RUN;
        else if (Halt) state_nxt = S_HALTED;
      end
      S_HALTED: if (Redirect && redirect_ok) state_nxt = S_RUN;
      default:  state_nxt = S_FLUSH;
    endcase
  end

  always_comb begin
    Halted    = (state == S_HALTED);
    dbg_state = state;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Pc           <= RESET_PC;
      IfId_Inst    <= 32'h0;
      IfId_PcPlus4 <= 32'h0;
      IfId_Valid   <= 1'b0;
      FetchCount   <= 32'h0;
    end else begin
      case (state)
        S_RUN: begin
          if (Redirect) begin
            if (redirect_ok) Pc <= redirect_target;
            IfId_Inst  <= 32'h0;
            IfId_Valid <= 1'b0;
          end else if (Halt) begin
            IfId_Inst  <= 32'h0;
            IfId_Valid <= 1'b0;
          end else if (!Stall) begin
            IfId_Inst    <= InstIn;
            IfId_PcPlus4 <= pc_plus;
            IfId_Valid   <= 1'b1;
            Pc           <= pc_plus;
            FetchCount   <= FetchCount + 32'd1;
          end
        end
        S_HALTED: begin
          IfId_Valid <= 1'b0;
          if (Redirect && redirect_ok) Pc <= redirect_target;
        end
        default: IfId_Valid <= 1'b0;
      endcase
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge Clk) begin
    if (Rst)
      MisalignErr <= 1'b0;
    else if (Redirect && !redirect_ok && (state != S_FLUSH))
      MisalignErr <= 1'b1;
  end
`else
  assign MisalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: expected IF/ID instructions go into a
// queue as each fetch is driven and are popped when the IF/ID register updates.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst, Stall, Redirect, Halt;
  logic [31:0] RedirectPc;
  logic [31:0] InstIn;
  logic [31:0] Pc, IfId_Inst, IfId_PcPlus4, FetchCount;
  logic        IfId_Valid, Halted, MisalignErr;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  logic [31:0] got;
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_stage dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Redirect(Redirect),
    .RedirectPc(RedirectPc), .Halt(Halt), .InstIn(InstIn),
    .Pc(Pc), .IfId_Inst(IfId_Inst), .IfId_PcPlus4(IfId_PcPlus4),
    .IfId_Valid(IfId_Valid), .Halted(Halted), .FetchCount(FetchCount),
    .MisalignErr(MisalignErr), .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  // Combinational instruction memory: word content depends on its address.
  assign InstIn = 32'h2000_0000 | Pc;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; Halt = 1'b0; RedirectPc = 32'h0;
    step();
    step();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Stall = 1'b1; Redirect = 1'b1; Halt = 1'b0; RedirectPc = 32'h80;
    step();
    step();
    n_cmp++; if (Pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", Pc, 32'h0); end
    n_cmp++; if (IfId_Inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got=%h exp=%h", IfId_Inst, 32'h0); end
    n_cmp++; if (IfId_PcPlus4 !== 32'h0) begin n_err++; $display("FAIL reset_pcp4 got=%h exp=%h", IfId_PcPlus4, 32'h0); end
    n_cmp++; if (IfId_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", IfId_Valid); end
    n_cmp++; if (Halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got=%b exp=0", Halted); end
    n_cmp++; if (FetchCount !== 32'h0) begin n_err++; $display("FAIL reset_count got=%h exp=0", FetchCount); end
    n_cmp++; if (MisalignErr !== 1'b0) begin n_err++; $display("FAIL reset_misalign got=%b exp=0", MisalignErr); end
    Rst = 1'b0; Stall = 1'b0; Redirect = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    step();
    n_cmp++; if (IfId_Valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b exp=0", IfId_Valid); end
    n_cmp++; if (Pc !== 32'h0) begin n_err++; $display("FAIL flush_pc got=%h exp=0", Pc); end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h2000_0000 | (32'(i) * 32'd4));
      step();
      got = exp_q.pop_front();
      n_cmp++; if (IfId_Inst !== got) begin n_err++; $display("FAIL seq_inst%0d got=%h exp=%h", i, IfId_Inst, got); end
      n_cmp++; if (Pc !== 32'(i + 1) * 32'd4) begin n_err++; $display("FAIL seq_pc%0d got=%h exp=%h", i, Pc, 32'(i + 1) * 32'd4); end
      n_cmp++; if (IfId_PcPlus4 !== 32'(i + 1) * 32'd4) begin n_err++; $display("FAIL seq_pcp4_%0d got=%h exp=%h", i, IfId_PcPlus4, 32'(i + 1) * 32'd4); end
      n_cmp++; if (IfId_Valid !== 1'b1) begin n_err++; $display("FAIL seq_valid%0d got=%b exp=1", i, IfId_Valid); end
    end
    n_cmp++; if (FetchCount !== 32'd3) begin n_err++; $display("FAIL seq_count got=%0d exp=3", FetchCount); end
  endtask

  task automatic test_flush_halt();
    Rst = 1'b1; Halt = 1'b1; Stall = 1'b0; Redirect = 1'b0;
    step();
    Rst = 1'b0;
    step();
    n_cmp++; if (Halted !== 1'b1) begin n_err++; $display("FAIL flush_halt got=%b exp=1", Halted); end
    n_cmp++; if (Pc !== 32'h0) begin n_err++; $display("FAIL flush_halt_pc got=%h exp=0", Pc); end
    Halt = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      Stall = 1'b1;
      step();
      n_cmp++; if (Pc !== 32'h8) begin n_err++; $display("FAIL stall_pc%0d got=%h exp=8", i, Pc); end
      n_cmp++; if (IfId_Inst !== 32'h2000_0004) begin n_err++; $display("FAIL stall_inst%0d got=%h exp=20000004", i, IfId_Inst); end
      n_cmp++; if (IfId_PcPlus4 !== 32'h8) begin n_err++; $display("FAIL stall_pcp4_%0d got=%h exp=8", i, IfId_PcPlus4); end
      n_cmp++; if (IfId_Valid !== 1'b1) begin n_err++; $display("FAIL stall_valid%0d got=%b exp=1", i, IfId_Valid); end
      n_cmp++; if (FetchCount !== 32'd2) begin n_err++; $display("FAIL stall_count%0d got=%0d exp=2", i, FetchCount); end
    end
    Stall = 1'b0;
    exp_q.push_back(32'h2000_0008);
    step();
    got = exp_q.pop_front();
    n_cmp++; if (IfId_Inst !== got) begin n_err++; $display("FAIL unstall_inst got=%h exp=%h", IfId_Inst, got); end
    n_cmp++; if (Pc !== 32'hC) begin n_err++; $display("FAIL unstall_pc got=%h exp=c", Pc); end
    n_cmp++; if (FetchCount !== 32'd3) begin n_err++; $display("FAIL unstall_count got=%0d exp=3", FetchCount); end
  endtask

  task automatic test_redirect_stall();
    Stall = 1'b1; Redirect = 1'b1; RedirectPc = 32'h40;
    step();
    Stall = 1'b0; Redirect = 1'b0;
    n_cmp++; if (Pc !== 32'h40) begin n_err++; $display("FAIL redir_pc got=%h exp=40", Pc); end
    n_cmp++; if (IfId_Valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got=%b exp=0", IfId_Valid); end
    n_cmp++; if (IfId_Inst !== 32'h0) begin n_err++; $display("FAIL redir_inst got=%h exp=0", IfId_Inst); end
    n_cmp++; if (FetchCount !== 32'd3) begin n_err++; $display("FAIL redir_count got=%0d exp=3", FetchCount); end
    exp_q.push_back(32'h2000_0040);
    step();
    got = exp_q.pop_front();
    n_cmp++; if (IfId_PcPlus4 !== 32'h44) begin n_err++; $display("FAIL redir_pcp4 got=%h exp=44", IfId_PcPlus4); end
    n_cmp++; if (IfId_Inst !== got) begin n_err++; $display("FAIL redir_next_inst got=%h exp=%h", IfId_Inst, got); end
    n_cmp++; if (FetchCount !== 32'd4) begin n_err++; $display("FAIL redir_next_count got=%0d exp=4", FetchCount); end
  endtask

  task automatic test_halt_resume();
    Redirect = 1'b1; RedirectPc = 32'h10;
    step();
    Redirect = 1'b0; Halt = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      Stall = 1'($urandom_range(0, 1));
      n_cmp++; if (Halted !== 1'b1) begin n_err++; $display("FAIL halt_flag%0d got=%b exp=1", i, Halted); end
      n_cmp++; if (Pc !== 32'h10) begin n_err++; $display("FAIL halt_pc%0d got=%h exp=10", i, Pc); end
      n_cmp++; if (IfId_Valid !== 1'b0) begin n_err++; $display("FAIL halt_valid%0d got=%b exp=0", i, IfId_Valid); end
      step();
    end
    n_cmp++; if (FetchCount !== 32'd4) begin n_err++; $display("FAIL halt_count got=%0d exp=4", FetchCount); end
    Stall = 1'b0; Halt = 1'b0; Redirect = 1'b1; RedirectPc = 32'h100;
    step();
    Redirect = 1'b0;
    n_cmp++; if (Halted !== 1'b0) begin n_err++; $display("FAIL resume_halted got=%b exp=0", Halted); end
    n_cmp++; if (Pc !== 32'h100) begin n_err++; $display("FAIL resume_pc got=%h exp=100", Pc); end
    exp_q.push_back(32'h2000_0100);
    step();
    got = exp_q.pop_front();
    n_cmp++; if (IfId_Valid !== 1'b1) begin n_err++; $display("FAIL resume_valid got=%b exp=1", IfId_Valid); end
    n_cmp++; if (IfId_Inst !== got) begin n_err++; $display("FAIL resume_inst got=%h exp=%h", IfId_Inst, got); end
  endtask

  task automatic test_wrap();
    Redirect = 1'b1; RedirectPc = 32'hFFFF_FFFC;
    step();
    Redirect = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    step();
    got = exp_q.pop_front();
    n_cmp++; if (Pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got=%h exp=0", Pc); end
    n_cmp++; if (IfId_PcPlus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pcp4 got=%h exp=0", IfId_PcPlus4); end
    n_cmp++; if (IfId_Inst !== got) begin n_err++; $display("FAIL wrap_inst got=%h exp=%h", IfId_Inst, got); end
  endtask

  task automatic test_misalign();
    Redirect = 1'b1; RedirectPc = 32'h42;
    step();
    Redirect = 1'b0; Stall = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
    n_cmp++; if (Pc !== 32'h0) begin n_err++; $display("FAIL misalign_pc got=%h exp=0", Pc); end
    n_cmp++; if (IfId_Valid !== 1'b0) begin n_err++; $display("FAIL misalign_valid got=%b exp=0", IfId_Valid); end
    n_cmp++; if (MisalignErr !== 1'b1) begin n_err++; $display("FAIL misalign_err got=%b exp=1", MisalignErr); end
    step();
    step();
    n_cmp++; if (MisalignErr !== 1'b1) begin n_err++; $display("FAIL misalign_sticky got=%b exp=1", MisalignErr); end
`else
    n_cmp++; if (Pc !== 32'h40) begin n_err++; $display("FAIL misalign_pc got=%h exp=40", Pc); end
    n_cmp++; if (IfId_Valid !== 1'b0) begin n_err++; $display("FAIL misalign_valid got=%b exp=0", IfId_Valid); end
    n_cmp++; if (MisalignErr !== 1'b0) begin n_err++; $display("FAIL misalign_err got=%b exp=0", MisalignErr); end
`endif
    Stall = 1'b0;
    do_reset();
    n_cmp++; if (MisalignErr !== 1'b0) begin n_err++; $display("FAIL misalign_clear got=%b exp=0", MisalignErr); end
  endtask

  task automatic test_random_stall();
    logic [31:0] pc_e;
    logic [31:0] cnt_e;
    logic        s;
    do_reset();
    step();
    pc_e = 32'h0;
    cnt_e = 32'h0;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      Stall = s;
      if (!s) begin
        exp_q.push_back(32'h2000_0000 | pc_e);
        pc_e = pc_e + 32'd4;
        cnt_e = cnt_e + 32'd1;
      end
      step();
      if (!s) begin
        got = exp_q.pop_front();
        n_cmp++; if (IfId_Inst !== got) begin n_err++; $display("FAIL rnd_inst%0d got=%h exp=%h", i, IfId_Inst, got); end
      end
      n_cmp++; if (Pc !== pc_e) begin n_err++; $display("FAIL rnd_pc%0d got=%h exp=%h", i, Pc, pc_e); end
      n_cmp++; if (FetchCount !== cnt_e) begin n_err++; $display("FAIL rnd_count%0d got=%0d exp=%0d", i, FetchCount, cnt_e); end
    end
    Stall = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; Halt = 1'b0; RedirectPc = 32'h0;
    test_reset();
    test_sequential();
    test_flush_halt();
    test_stall();
    test_redirect_stall();
    test_halt_resume();
    test_wrap();
    test_misalign();
    test_random_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
